// File: rtl/voq_scheduler.sv
// Round-robin crossbar scheduler: snapshots VOQ empty flags, matches one egress per cycle,
// then presents a registered ingress->egress matching for one cycle.
//   state  | meaning
//   S_IDLE | waiting for sched_en
//   S_ITER | one egress arbitrated per cycle
//   S_DONE | matching presented on outputs for one cycle
module voq_scheduler #(
    parameter int PORT_CNT = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  sched_en,
    input  logic [PORT_CNT*PORT_CNT-1:0]          voq_empty,
    output logic                                  busy,
    output logic                                  sched_valid,
    output logic [PORT_CNT-1:0]                   voq_dequeue_en,
    output logic [PORT_CNT*$clog2(PORT_CNT)-1:0]  voq_dequeue_sel
);
    localparam int SW = $clog2(PORT_CNT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                     state_q, state_d;
    logic [SW-1:0]                  grant_ptr_q [PORT_CNT];
    logic [SW-1:0]                  grant_ptr_d [PORT_CNT];
    logic [SW-1:0]                  start_eg_q, start_eg_d;
    logic [PORT_CNT*PORT_CNT-1:0]   snap_q, snap_d;
    logic [PORT_CNT-1:0]            matched_q, matched_d;
    logic [SW-1:0]                  match_eg_q [PORT_CNT];
    logic [SW-1:0]                  match_eg_d [PORT_CNT];
    logic [SW:0]                    step_q, step_d;

    logic                           busy_q, busy_d;
    logic                           sched_valid_q, sched_valid_d;
    logic [PORT_CNT-1:0]            dq_en_q, dq_en_d;
    logic [PORT_CNT*SW-1:0]         dq_sel_q, dq_sel_d;

    logic [SW-1:0]                  cur_eg;
    logic [SW-1:0]                  cand;
    logic                           hit;
    logic [SW-1:0]                  hit_ing;

    always_comb begin
        state_d     = state_q;
        grant_ptr_d = grant_ptr_q;
        start_eg_d  = start_eg_q;
        snap_d      = snap_q;
        matched_d   = matched_q;
        match_eg_d  = match_eg_q;
        step_d      = step_q;

        // Search the current egress starting at its pointer for the first unmatched requester.
        cur_eg  = start_eg_q + step_q[SW-1:0];
        cand    = '0;
        hit     = 1'b0;
        hit_ing = '0;
        for (int k = 0; k < PORT_CNT; k++) begin
            cand = grant_ptr_q[cur_eg] + SW'(k);
            if (!hit && !matched_q[cand] && !snap_q[{cand, cur_eg}]) begin
                hit     = 1'b1;
                hit_ing = cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sched_en) begin
                    snap_d    = voq_empty;
                    matched_d = '0;
                    for (int i = 0; i < PORT_CNT; i++) match_eg_d[i] = '0;
                    step_d    = '0;
                    state_d   = S_ITER;
                end
            end
            S_ITER: begin
                if (hit) begin
                    matched_d[hit_ing]  = 1'b1;
                    match_eg_d[hit_ing] = cur_eg;
                    grant_ptr_d[cur_eg] = hit_ing + 1'b1;
                end
                step_d = step_q + 1'b1;
                if (step_q == (SW+1)'(PORT_CNT-1)) state_d = S_DONE;
            end
            S_DONE: begin
                start_eg_d = start_eg_q + 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are computed from the next-state values.
        busy_d        = (state_d != S_IDLE);
        sched_valid_d = (state_d == S_DONE);
        dq_en_d       = sched_valid_d ? matched_d : '0;
        dq_sel_d      = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            dq_sel_d[i*SW +: SW] = sched_valid_d ? match_eg_d[i] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            start_eg_q    <= '0;
            snap_q        <= '1;
            matched_q     <= '0;
            step_q        <= '0;
            busy_q        <= 1'b0;
            sched_valid_q <= 1'b0;
            dq_en_q       <= '0;
            dq_sel_q      <= '0;
            for (int i = 0; i < PORT_CNT; i++) begin
                grant_ptr_q[i] <= '0;
                match_eg_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            start_eg_q    <= start_eg_d;
            snap_q        <= snap_d;
            matched_q     <= matched_d;
            step_q        <= step_d;
            busy_q        <= busy_d;
            sched_valid_q <= sched_valid_d;
            dq_en_q       <= dq_en_d;
            dq_sel_q      <= dq_sel_d;
            for (int i = 0; i < PORT_CNT; i++) begin
                grant_ptr_q[i] <= grant_ptr_d[i];
                match_eg_q[i]  <= match_eg_d[i];
            end
        end
    end

    assign busy            = busy_q;
    assign sched_valid     = sched_valid_q;
    assign voq_dequeue_en  = dq_en_q;
    assign voq_dequeue_sel = dq_sel_q;

endmodule

// File: tb/tb_voq_scheduler.sv
// Scoreboard bench for voq_scheduler: a round-level reference model predicts each matching
// at acceptance time; a negedge monitor checks timing and pops predictions on sched_valid.
module tb_voq_scheduler;
    localparam int P  = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [P-1:0]    en;
        logic [P*SW-1:0] sel;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              sched_en;
    logic [P*P-1:0]    voq_empty;
    logic              busy;
    logic              sched_valid;
    logic [P-1:0]      voq_dequeue_en;
    logic [P*SW-1:0]   voq_dequeue_sel;

    voq_scheduler #(.PORT_CNT(P)) dut (
        .clk             (clk),
        .reset           (reset),
        .sched_en        (sched_en),
        .voq_empty       (voq_empty),
        .busy            (busy),
        .sched_valid     (sched_valid),
        .voq_dequeue_en  (voq_dequeue_en),
        .voq_dequeue_sel (voq_dequeue_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int   m_gp [P];
    int   m_start;
    int   cyc       = 0;
    int   next_idle = 0;
    int   last_acc  = -100;
    exp_t exp_q [$];

    int              n_valid = 0;
    logic [P-1:0]    last_en;
    logic [P*SW-1:0] last_sel;

    function automatic exp_t model_round(input logic [P*P-1:0] pat);
        exp_t r;
        bit   matched [P];
        int   e, i;
        r.en  = '0;
        r.sel = '0;
        for (int k = 0; k < P; k++) matched[k] = 1'b0;
        for (int s = 0; s < P; s++) begin
            e = (m_start + s) % P;
            for (int k = 0; k < P; k++) begin
                i = (m_gp[e] + k) % P;
                if (!matched[i] && pat[i*P+e] == 1'b0) begin
                    matched[i]         = 1'b1;
                    r.en[i]            = 1'b1;
                    r.sel[2*i +: 2]    = e[1:0];
                    m_gp[e]            = (i + 1) % P;
                    break;
                end
            end
        end
        m_start = (m_start + 1) % P;
        return r;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            for (int k = 0; k < P; k++) m_gp[k] = 0;
            m_start   = 0;
            next_idle = 0;
            last_acc  = -100;
            exp_q.delete();
        end else if (sched_en && cyc >= next_idle) begin
            exp_q.push_back(model_round(voq_empty));
            last_acc  = cyc;
            next_idle = cyc + P + 2;
        end
    end

    always @(negedge clk) begin
        exp_t x;
        logic exp_busy, exp_valid;
        if (reset) begin
            exp_busy  = (cyc >= last_acc) && (cyc <= last_acc + P);
            exp_valid = (cyc == last_acc + P);
            checks++;
            if (busy !== exp_busy || sched_valid !== exp_valid) begin
                failures++;
                $display("FAIL timing cyc=%0d busy=%b/%b valid=%b/%b (got/exp)",
                         cyc, busy, exp_busy, sched_valid, exp_valid);
            end
            checks++;
            if (sched_valid === 1'b1) begin
                n_valid++;
                last_en  = voq_dequeue_en;
                last_sel = voq_dequeue_sel;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid cyc=%0d en=%b sel=%h", cyc, voq_dequeue_en, voq_dequeue_sel);
                end else begin
                    x = exp_q.pop_front();
                    if (voq_dequeue_en !== x.en || voq_dequeue_sel !== x.sel) begin
                        failures++;
                        $display("FAIL match cyc=%0d en=%b exp=%b sel=%h exp=%h",
                                 cyc, voq_dequeue_en, x.en, voq_dequeue_sel, x.sel);
                    end
                end
            end else if (voq_dequeue_en !== '0 || voq_dequeue_sel !== '0) begin
                failures++;
                $display("FAIL idle_outputs cyc=%0d en=%b sel=%h exp 0", cyc, voq_dequeue_en, voq_dequeue_sel);
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (busy !== 1'b0 || sched_valid !== 1'b0 || voq_dequeue_en !== '0 || voq_dequeue_sel !== '0) begin
            failures++;
            $display("FAIL %s busy=%b valid=%b en=%b sel=%h exp all 0",
                     name, busy, sched_valid, voq_dequeue_en, voq_dequeue_sel);
        end
    endtask

    task automatic check_out(input string name, input logic [P-1:0] en, input logic [P*SW-1:0] sel);
        checks++;
        if (last_en !== en || last_sel !== sel) begin
            failures++;
            $display("FAIL %s en=%b exp=%b sel=%h exp=%h", name, last_en, en, last_sel, sel);
        end
    endtask

    // Issues one round; returns negedges from raising sched_en to seeing sched_valid.
    task automatic run_round(input logic [P*P-1:0] pat, output int lat);
        @(negedge clk);
        voq_empty = pat;
        sched_en  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                sched_en  = 1'b0;
                voq_empty = 16'($urandom);
            end
        end while (sched_valid !== 1'b1 && lat < 20);
        if (sched_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL round_timeout lat=%0d exp 5", lat);
        end
    endtask

    initial begin
        int lat;
        int nv0;
        logic [P*P-1:0] pat;
        reset     = 1'b0;
        sched_en  = 1'b0;
        voq_empty = '1;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_zero("after_reset");

        run_round('0, lat);
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL latency got=%0d exp=5", lat);
        end
        check_out("all_nonempty_r1", 4'b1111, 8'hE4);
        run_round('0, lat);
        check_out("all_nonempty_r2", 4'b1111, 8'h93);

        run_round(16'hFDFF, lat);
        check_out("single_cand_a", 4'b0100, 8'h10);
        run_round(16'hFDFF, lat);
        check_out("single_cand_b", 4'b0100, 8'h10);

        run_round(16'hFFF0, lat);
        check_out("contention", 4'b0001, 8'h00);

        run_round('1, lat);
        check_out("all_empty", 4'b0000, 8'h00);

        @(negedge clk);
        nv0       = n_valid;
        sched_en  = 1'b1;
        repeat (20) begin
            voq_empty = 16'($urandom);
            @(negedge clk);
        end
        sched_en = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (n_valid - nv0 != 4) begin
            failures++;
            $display("FAIL held_sched_en valids=%0d exp=4", n_valid - nv0);
        end

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 2))
                0: pat = 16'($urandom) & 16'($urandom);
                1: pat = 16'($urandom) | 16'($urandom);
                default: pat = 16'($urandom);
            endcase
            run_round(pat, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        voq_empty = '0;
        sched_en  = 1'b1;
        @(negedge clk);
        sched_en  = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero("reset_mid_iter");
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        #2 reset = 1'b1;
        run_round('0, lat);
        check_out("post_reset_r1", 4'b1111, 8'hE4);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected count=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voq_scheduler.md
# voq_scheduler

Round-robin crossbar scheduler for the fixed-length switch. Each scheduling round it samples the per-ingress VOQ empty flags from every ingress `vmu` and computes a conflict-free ingress-to-egress matching. Each ingress and each egress appears in at most one pair. It then drives each ingress `vmu`'s dequeue enable and select for one cycle. It sits between the ingress `vmu` instances and the crossbar/egress datapath.

## Interface
- `PORT_CNT`, 4: number of ingress ports, equal to the number of egress ports; must be a power of two, at least 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `sched_en`  in  1  pulse: start a scheduling round.
- `voq_empty`  in  PORT_CNT*PORT_CNT  bit `i*PORT_CNT+e` is ingress `i`'s `is_empty[e]`.
- `busy`  out  1  high while a round is in progress.
- `sched_valid`  out  1  one-cycle pulse when the matching outputs are valid.
- `voq_dequeue_en`  out  PORT_CNT  bit `i` is the dequeue enable for ingress `i`.
- `voq_dequeue_sel`  out  PORT_CNT*clog2(PORT_CNT)  field `i` is the egress selected for ingress `i`.

## Operation
- State
  - FSM states: IDLE, ITER, DONE.
  - Per-egress round-robin pointer `grant_ptr[e]`, clog2(PORT_CNT) bits.
  - Rotating start egress `start_eg`, clog2(PORT_CNT) bits.
  - Snapshot register `snap`, holding the sampled `voq_empty`.
  - Ingress-matched mask.
  - Egress step counter `step`, clog2(PORT_CNT)+1 bits.
- IDLE
  - On `sched_en`: capture `voq_empty` into `snap`, clear the matched mask and all pending grants, set `step`=0, go to ITER.
  - `sched_en` is accepted only in IDLE. It is ignored in ITER and DONE; it is not queued.
- ITER, one egress per cycle
  - Current egress `e = (start_eg + step) mod PORT_CNT`.
  - Search ingresses `i = grant_ptr[e]`, `grant_ptr[e]+1`, … (mod PORT_CNT) for the first `i` that is unmatched and has `snap[i*PORT_CNT+e]==0`.
  - On a hit:
    - record the pair (i, e);
    - set matched[i];
    - set `grant_ptr[e] <= (i+1) mod PORT_CNT`.
  - On a miss: `grant_ptr[e]` is unchanged.
  - `step` increments each cycle. After the step where `step==PORT_CNT-1`, go to DONE.
- DONE, one cycle
  - `sched_valid`=1.
  - `voq_dequeue_en[i]`=matched[i].
  - `voq_dequeue_sel` field `i` = the egress matched to ingress `i`, or 0 if ingress `i` is unmatched.
  - `start_eg` increments mod PORT_CNT. The wrap from PORT_CNT-1 to 0 is a normal wrap.
  - Next state IDLE.
- Outside DONE, `voq_dequeue_en`=0, `sched_valid`=0 and `voq_dequeue_sel`=0.
- A round with no candidates still passes through DONE: `sched_valid` pulses with `voq_dequeue_en`=0, and only `start_eg` advances.
- Input changes after capture do not affect the round in progress.

## Timing
- `sched_en` sampled high in IDLE at edge t:
  - ITER occupies edges t+1 … t+PORT_CNT;
  - DONE outputs are registered and valid in the cycle after edge t+PORT_CNT.
- Latency from `sched_en` to `sched_valid` is PORT_CNT+1 cycles. Back-to-back rounds start at most every PORT_CNT+2 cycles.
- `busy`=1 from the cycle after acceptance through DONE, and 0 in IDLE.
- `vmu` consumes `voq_dequeue_en`/`voq_dequeue_sel` in the same cycle `sched_valid` is high. The `vmu`'s own empty guard makes a stale grant harmless.
- Reset asserted, at any time including mid-ITER:
  - immediately: state IDLE and all outputs 0;
  - `grant_ptr[*]`=0, `start_eg`=0, `snap`=all ones, `step`=0;
  - any partial matching is discarded.
- All outputs are driven from registers; there is no combinational path from `voq_empty` or `sched_en` to any output.

## Test plan
- Reset and idle: hold `reset`=0, then release → `busy`=0, `sched_valid`=0, `voq_dequeue_en`=0. Pulse `sched_en` → `sched_valid` high exactly 5 cycles later, `busy` high 4 cycles before it.
- All VOQs non-empty (`voq_empty`=0), two consecutive rounds:
  - round 1: `voq_dequeue_en`=4'b1111, sel per ingress 0..3 = {0,1,2,3};
  - round 2 (`start_eg`=1): sel = {3,0,1,2}.
- Single candidate: only bit 9 clear (ingress 2 → egress 1) → `voq_dequeue_en`=4'b0100, ingress 2 sel=1, and `grant_ptr[1]` becomes 3. Repeat the round → same grant.
- Contention: ingress 0 non-empty for all egresses, every other ingress empty, `start_eg`=0 → only egress 0 grants; `voq_dequeue_en`=4'b0001, sel[0]=0.
- All empty (`voq_empty`=all ones) → `sched_valid` pulse with `voq_dequeue_en`=0; `grant_ptr` unchanged, `start_eg` advanced.
- Robustness:
  - `sched_en` held high during ITER → exactly one `sched_valid` per IDLE acceptance;
  - change `voq_empty` mid-round → result reflects the snapshot;
  - assert `reset` during ITER step 2 → outputs 0 immediately, and a fresh round after release behaves as round 1 of the all-non-empty scenario.
